// File: rtl/sequence_generator_pkg.sv
// sequence_generator_pkg: shared state encoding, default widths and length clamp helper.
package sequence_generator_pkg;
  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_LEN_W = 4;
  localparam int unsigned DEF_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_w);
    return (len == 0 || len > max_w) ? max_w : len;
  endfunction
endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: MSB-first frame shifter with bit down-counter, running parity and last-bit flag.
module seq_gen_shreg #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_i,
  input  logic             rs_i,
  input  logic             sh_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             nb_o,
  output logic             last_o,
  output logic             par_o
);
  logic [PAT_W-1:0] pat_q, sr_q, aligned, src;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             par_q;
  // Left-align the pattern so the first bit always sits at the MSB.
  assign aligned = pat_i << (PAT_W - int'(len_i));
  assign src     = ld_i ? aligned : rs_i ? pat_q : sr_q;
  assign nb_o    = src[PAT_W-1];
  assign last_o  = cnt_q == '0;
  assign par_o   = par_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q <= '0;
      len_q <= '0;
      sr_q  <= '0;
      cnt_q <= '0;
      par_q <= 1'b0;
    end else begin
      if (ld_i) begin
        pat_q <= aligned;
        len_q <= len_i;
      end
      if (ld_i || rs_i || sh_i) begin
        sr_q  <= src << 1;
        cnt_q <= (ld_i ? len_i : rs_i ? len_q : cnt_q) - 1'b1;
        par_q <= (sh_i & par_q) ^ nb_o;
      end
    end
  end
endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serial MSB-first pattern transmitter with repeat count and abort.
// Build option SEQUENCE_GENERATOR_PARITY_EN appends an even-parity bit after every frame.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pattern,
  input  logic [LEN_W-1:0] load_len,
  input  logic [CNT_W-1:0] load_repeat,
  input  logic             abort,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);
`ifdef SEQUENCE_GENERATOR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  state_t           state_q;
  logic [CNT_W-1:0] frm_q;
  logic             data_out_q, data_valid_q, done_q;
  logic [LEN_W-1:0] len_c;
  logic             nb, last, par, fin, ld, rs, sh;
  assign len_c = LEN_W'(clamp_len(int'(load_len), PAT_W));
  // fin: the cycle presenting the final bit of a frame (parity bit when enabled)
  assign fin = (state_q == SHIFT && last && !PAR_EN) || state_q == PAR;
  assign ld  = reset && !abort && state_q == IDLE && load_valid;
  assign rs  = reset && !abort && fin && frm_q != '0;
  assign sh  = reset && !abort && state_q == SHIFT && !last;
  seq_gen_shreg #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shreg (
    .clk    (clk),
    .reset  (reset),
    .ld_i   (ld),
    .rs_i   (rs),
    .sh_i   (sh),
    .pat_i  (load_pattern),
    .len_i  (len_c),
    .nb_o   (nb),
    .last_o (last),
    .par_o  (par)
  );
  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      state_q      <= IDLE;
      frm_q        <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (state_q == IDLE) begin
      state_q      <= load_valid ? SHIFT : IDLE;
      frm_q        <= load_valid ? load_repeat : frm_q;
      data_out_q   <= load_valid && nb;
      data_valid_q <= load_valid;
      done_q       <= 1'b0;
    end else if (fin) begin
      state_q      <= frm_q != '0 ? SHIFT : IDLE;
      frm_q        <= frm_q - CNT_W'(frm_q != '0);
      data_out_q   <= frm_q != '0 && nb;
      data_valid_q <= frm_q != '0;
      done_q       <= frm_q == '0;
    end else if (last) begin
      state_q    <= PAR;
      data_out_q <= par;
    end else begin
      data_out_q <= nb;
    end
  end
  assign load_ready = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed checks of load, repeat, clamp, busy-ignore, abort and back-to-back jobs.
module tb_sequence_generator;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_pattern = '0;
  logic [3:0] load_len = '0;
  logic [3:0] load_repeat = '0;
  logic       abort = 1'b0;
  logic       data_out, data_valid, busy, done;
  int         checks = 0;
  int         failures = 0;
  logic       exp_q[$];

  sequence_generator dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_repeat  (load_repeat),
    .abort        (abort),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void build(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    int n;
    logic pb;
    exp_q.delete();
    n = (l == 0 || l > 8) ? 8 : int'(l);
    for (int f = 0; f <= int'(r); f++) begin
      pb = 1'b0;
      for (int b = n - 1; b >= 0; b--) begin
        exp_q.push_back(p[b]);
        pb ^= p[b];
      end
      if (PAR_EN) exp_q.push_back(pb);
    end
  endfunction

  task automatic run_job(input string nm, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input int poke);
    build(p, l, r);
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_load got=%b want=1", nm, load_ready);
    end
    load_valid = 1'b1; load_pattern = p; load_len = l; load_repeat = r;
    tick();
    load_valid = 1'b0; load_pattern = '0; load_len = '0; load_repeat = '0;
    foreach (exp_q[i]) begin
      checks++;
      if ({data_valid, data_out, busy, done, load_ready} !== {1'b1, exp_q[i], 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s bit%0d valid/out/busy/done/ready got=%b%b%b%b%b want=1%b100",
                 nm, i, data_valid, data_out, busy, done, load_ready, exp_q[i]);
      end
      if (i == poke) begin
        load_valid = 1'b1; load_pattern = 8'hFF; load_len = 4'd2; load_repeat = 4'd3;
      end
      tick();
      load_valid = 1'b0; load_pattern = '0; load_len = '0; load_repeat = '0;
    end
    checks++;
    if ({data_valid, data_out, busy, done, load_ready} !== 5'b00011) begin
      failures++;
      $display("FAIL %s end valid/out/busy/done/ready got=%b%b%b%b%b want=00011",
               nm, data_valid, data_out, busy, done, load_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; load_pattern = 8'hFF; load_len = 4'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({data_out, data_valid, busy, done} !== 4'b0000) begin
        failures++;
        $display("FAIL reset cyc%0d out/valid/busy/done got=%b%b%b%b want=0000",
                 i, data_out, data_valid, busy, done);
      end
    end
    load_valid = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if ({load_ready, data_valid, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_release ready/valid/busy/done got=%b%b%b%b want=1000",
               load_ready, data_valid, busy, done);
    end
  endtask

  task automatic test_abort();
    load_valid = 1'b1; load_pattern = 8'b1100_1010; load_len = 4'd8; load_repeat = 4'd0;
    tick();
    load_valid = 1'b0;
    checks++;
    if ({data_valid, data_out} !== 2'b11) begin
      failures++;
      $display("FAIL abort_bit0 valid/out got=%b%b want=11", data_valid, data_out);
    end
    tick();
    checks++;
    if ({data_valid, data_out} !== 2'b11) begin
      failures++;
      $display("FAIL abort_bit1 valid/out got=%b%b want=11", data_valid, data_out);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({data_valid, data_out, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_stop valid/out/busy/done got=%b%b%b%b want=0000",
               data_valid, data_out, busy, done);
    end
    tick();
    checks++;
    if ({done, load_ready, data_valid} !== 3'b010) begin
      failures++;
      $display("FAIL abort_idle done/ready/valid got=%b%b%b want=010", done, load_ready, data_valid);
    end
    abort = 1'b1; load_valid = 1'b1; load_pattern = 8'hFF; load_len = 4'd3;
    tick();
    abort = 1'b0; load_valid = 1'b0;
    checks++;
    if ({data_valid, busy, load_ready} !== 3'b001) begin
      failures++;
      $display("FAIL abort_beats_load valid/busy/ready got=%b%b%b want=001", data_valid, busy, load_ready);
    end
    run_job("abort_reload", 8'b0000_0110, 4'd3, 4'd0, -1);
  endtask

  task automatic test_mid_reset();
    load_valid = 1'b1; load_pattern = 8'hF0; load_len = 4'd8; load_repeat = 4'd1;
    tick();
    load_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({data_valid, busy, done, data_out} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset valid/busy/done/out got=%b%b%b%b want=0000", data_valid, busy, done, data_out);
    end
    tick();
  endtask

  initial begin
    test_reset();
    run_job("basic", 8'b0000_1011, 4'd4, 4'd0, -1);
    run_job("repeat", 8'b0000_1011, 4'd4, 4'd2, -1);
    run_job("clamp0_busy", 8'hA5, 4'd0, 4'd0, 3);
    run_job("clamp12", 8'h3C, 4'd12, 4'd0, -1);
    run_job("len1", 8'b0000_0001, 4'd1, 4'd1, -1);
    run_job("back_to_back", 8'b1001_0110, 4'd8, 4'd1, 5);
    test_abort();
    test_mid_reset();
    run_job("parity_frames", 8'b0000_1011, 4'd4, 4'd1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
